// File: rtl/cva6_pma_pkg.sv
// Shared types and register map for the runtime-programmable PMA table.
// Region fields are always 64 bits wide; lookups compare the low AddrWidth bits.
package cva6_pma_pkg;

  localparam int unsigned PMA_AW = 64;

  typedef struct packed {
    logic executable;
    logic idempotent;
    logic cacheable;
  } pma_attr_t;

  typedef struct packed {
    logic [PMA_AW-1:0] base;
    logic [PMA_AW-1:0] length;
    pma_attr_t         attr;
    logic              enable;
    logic              lock;
  } pma_region_t;

  // Per-region offsets (low 5 bits) and global register offsets.
  localparam logic [4:0] OFF_BASE   = 5'h00;
  localparam logic [4:0] OFF_LENGTH = 5'h08;
  localparam logic [4:0] OFF_ATTR   = 5'h10;
  localparam logic [7:0] OFF_CTRL   = 8'hF0;
  localparam logic [7:0] OFF_STATUS = 8'hF8;

  localparam int unsigned ATTR_EN_BIT   = 3;
  localparam int unsigned ATTR_LOCK_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } pma_state_e;

  function automatic pma_region_t region_rst(input logic [PMA_AW-1:0] base,
                                             input logic [PMA_AW-1:0] length);
    pma_region_t r;
    r.base   = base;
    r.length = length;
    r.attr   = '1;
    r.enable = 1'b1;
    r.lock   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/cva6_pma_match.sv
// Combinational priority matcher: lowest enabled region whose
// window contains the address wins; a miss returns DefaultAttr.
module cva6_pma_match
  import cva6_pma_pkg::*;
#(
  parameter int unsigned NrRegions   = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter logic [2:0]  DefaultAttr = 3'b100
) (
  input  logic [AddrWidth-1:0]          addr,
  input  pma_region_t [NrRegions-1:0]   regions,
  output logic                          hit,
  output logic [2:0]                    idx,
  output pma_attr_t                     attr
);

  logic [NrRegions-1:0] match;
  logic                 unused_lock;

  for (genvar i = 0; i < NrRegions; i++) begin : g_cmp
    logic [AddrWidth-1:0] off;
    // Unsigned wrap makes addr < base a huge offset, so it never matches.
    assign off      = addr - regions[i].base[AddrWidth-1:0];
    assign match[i] = regions[i].enable && (off < regions[i].length[AddrWidth-1:0]);
  end

  always_comb begin
    unused_lock = 1'b0;
    for (int i = 0; i < int'(NrRegions); i++) unused_lock ^= regions[i].lock;
  end

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    attr = pma_attr_t'(DefaultAttr);
    for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit  = 1'b1;
        idx  = 3'(i);
        attr = regions[i].attr;
      end
    end
  end

endmodule

// File: rtl/cva6_pma_table.sv
// PMA table top: shadow/active region copies, config port, commit FSM
// and a two-stage lookup pipeline (S1 address register, S2 match result).
module cva6_pma_table
  import cva6_pma_pkg::*;
#(
  parameter int unsigned NrRegions   = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter logic [63:0] RstBase     = 64'h8000_0000,
  parameter logic [63:0] RstLength   = 64'h4000_0000,
  parameter logic [2:0]  DefaultAttr = 3'b100
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [7:0]           cfg_addr_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [2:0]           resp_idx_o,
  output logic [2:0]           resp_attr_o
);

  localparam int unsigned STAGES = 2;

  pma_region_t [NrRegions-1:0] shadow, active;
  pma_state_e                  state_q, state_d;
  logic                        pending_q;

  // ---------------- config decode ----------------
  logic [2:0]           cfg_idx;
  logic [4:0]           cfg_sub;
  logic [NrRegions-1:0] reg_sel;
  logic                 sel_ctrl, sel_status, sel_reg, locked_sel;
  logic                 cfg_fire, cfg_bad, commit;
  logic [63:0]          rdata_d;

  assign cfg_idx    = cfg_addr_i[7:5];
  assign cfg_sub    = cfg_addr_i[4:0];
  assign sel_ctrl   = (cfg_addr_i == OFF_CTRL);
  assign sel_status = (cfg_addr_i == OFF_STATUS);

  always_comb begin
    reg_sel    = '0;
    locked_sel = 1'b0;
    rdata_d    = '0;
    for (int i = 0; i < int'(NrRegions); i++) begin
      reg_sel[i] = (cfg_idx == 3'(i));
      if (reg_sel[i]) begin
        locked_sel = active[i].lock;
        case (cfg_sub)
          OFF_BASE:   rdata_d = shadow[i].base;
          OFF_LENGTH: rdata_d = shadow[i].length;
          OFF_ATTR:   rdata_d = {56'b0, shadow[i].lock, 3'b0, shadow[i].enable, shadow[i].attr};
          default:    rdata_d = '0;
        endcase
      end
    end
    if (sel_status) rdata_d = {61'b0, state_q, pending_q};
  end

  assign sel_reg  = (|reg_sel) &&
                    (cfg_sub == OFF_BASE || cfg_sub == OFF_LENGTH || cfg_sub == OFF_ATTR);
  assign cfg_bad  = !(sel_ctrl || sel_status || sel_reg) ||
                    (sel_reg && cfg_we_i && locked_sel);
  assign cfg_gnt_o = (state_q == ST_IDLE);
  assign cfg_fire  = cfg_req_i && cfg_gnt_o;
  assign commit    = cfg_fire && cfg_we_i && sel_ctrl && cfg_wdata_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_fire;
      cfg_err_o    <= cfg_fire && cfg_bad;
      cfg_rdata_o  <= (cfg_fire && !cfg_we_i && !cfg_bad) ? rdata_d : '0;
    end
  end

  // ---------------- shadow / active tables ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRegions); i++)
        shadow[i] <= (i == 0) ? region_rst(RstBase, RstLength) : pma_region_t'('0);
    end else if (cfg_fire && cfg_we_i && !cfg_bad && sel_reg) begin
      for (int i = 0; i < int'(NrRegions); i++) begin
        if (reg_sel[i]) begin
          case (cfg_sub)
            OFF_BASE:   shadow[i].base   <= cfg_wdata_i;
            OFF_LENGTH: shadow[i].length <= cfg_wdata_i;
            OFF_ATTR: begin
              shadow[i].attr   <= pma_attr_t'(cfg_wdata_i[2:0]);
              shadow[i].enable <= cfg_wdata_i[ATTR_EN_BIT];
              shadow[i].lock   <= cfg_wdata_i[ATTR_LOCK_BIT];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Locked regions are frozen until reset: the swap leaves them alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRegions); i++)
        active[i] <= (i == 0) ? region_rst(RstBase, RstLength) : pma_region_t'('0);
    end else if (state_q == ST_SWAP) begin
      for (int i = 0; i < int'(NrRegions); i++)
        if (!active[i].lock) active[i] <= shadow[i];
    end
  end

  // ---------------- commit FSM ----------------
  logic lookup_fire;

  assign lookup_ready_o = (state_q == ST_IDLE);
  assign lookup_fire    = lookup_valid_i && lookup_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit) state_d = ST_DRAIN;
      // Nothing enters S1 outside IDLE, so S1 is empty once this cycle ends.
      ST_DRAIN: if (!lookup_fire) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit)                  pending_q <= 1'b1;
      else if (state_q == ST_SWAP) pending_q <= 1'b0;
    end
  end

  // ---------------- lookup pipeline ----------------
  logic [STAGES:1]      vld_pipe;
  logic [AddrWidth-1:0] s1_addr;
  logic                 m_hit;
  logic [2:0]           m_idx;
  pma_attr_t            m_attr;

  cva6_pma_match #(
    .NrRegions   (NrRegions),
    .AddrWidth   (AddrWidth),
    .DefaultAttr (DefaultAttr)
  ) u_match (
    .addr    (s1_addr),
    .regions (active),
    .hit     (m_hit),
    .idx     (m_idx),
    .attr    (m_attr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe    <= '0;
      s1_addr     <= '0;
      resp_hit_o  <= 1'b0;
      resp_idx_o  <= '0;
      resp_attr_o <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], lookup_fire};
      if (lookup_fire) s1_addr <= lookup_addr_i;
      if (vld_pipe[1]) begin
        resp_hit_o  <= m_hit;
        resp_idx_o  <= m_idx;
        resp_attr_o <= m_attr;
      end
    end
  end

  assign resp_valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_cva6_pma_table.sv
// Self-checking bench for cva6_pma_table: directed scenarios plus randomized
// lookups against a table-level reference model.
module tb_cva6_pma_table;

  localparam int NR = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_req = 0, cfg_we = 0;
  logic [7:0]  cfg_addr = '0;
  logic [63:0] cfg_wdata = '0;
  logic        cfg_gnt, cfg_rvalid, cfg_err;
  logic [63:0] cfg_rdata;
  logic        lookup_valid = 0, lookup_ready;
  logic [63:0] lookup_addr = '0;
  logic        resp_valid, resp_hit;
  logic [2:0]  resp_idx, resp_attr;

  int checks = 0, errors = 0;

  cva6_pma_table #(.NrRegions(NR)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready), .lookup_addr_i(lookup_addr),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_idx_o(resp_idx), .resp_attr_o(resp_attr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // attr byte: bit0 cacheable, bit1 idempotent, bit2 executable, bit3 enable, bit7 lock
  logic [63:0] sh_base[NR], sh_len[NR], ac_base[NR], ac_len[NR];
  logic [7:0]  sh_attr[NR], ac_attr[NR];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      sh_base[i] = (i == 0) ? 64'h8000_0000 : 64'h0;
      sh_len[i]  = (i == 0) ? 64'h4000_0000 : 64'h0;
      sh_attr[i] = (i == 0) ? 8'h0F : 8'h00;
      ac_base[i] = sh_base[i]; ac_len[i] = sh_len[i]; ac_attr[i] = sh_attr[i];
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NR; i++)
      if (!ac_attr[i][7]) begin
        ac_base[i] = sh_base[i]; ac_len[i] = sh_len[i]; ac_attr[i] = sh_attr[i];
      end
  endfunction

  function automatic void model_lookup(input logic [63:0] a, output logic h,
                                       output logic [2:0] ix, output logic [2:0] at);
    h = 0; ix = 0; at = 3'b100;
    for (int i = 0; i < NR; i++)
      if (!h && ac_attr[i][3] && (a - ac_base[i]) < ac_len[i]) begin
        h = 1; ix = 3'(i); at = ac_attr[i][2:0];
      end
  endfunction

  // Expected config response; applies accepted shadow writes (commit is timed by caller).
  function automatic void model_cfg(input logic we, input logic [7:0] a, input logic [63:0] d,
                                    output logic [63:0] erd, output logic eerr);
    int r, off;
    erd = 0; eerr = 0;
    if (a == 8'hF0 || a == 8'hF8) return;
    r = int'(a) / 32; off = int'(a) % 32;
    if (r >= NR || !(off == 0 || off == 8 || off == 16)) begin eerr = 1; return; end
    if (we) begin
      if (ac_attr[r][7]) begin eerr = 1; return; end
      if (off == 0) sh_base[r] = d;
      else if (off == 8) sh_len[r] = d;
      else sh_attr[r] = d[7:0] & 8'h8F;
    end else begin
      erd = (off == 0) ? sh_base[r] : (off == 8) ? sh_len[r] : {56'b0, sh_attr[r]};
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cfg_xfer(input logic we, input logic [7:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output logic ok);
    int n = 0;
    cfg_req = 1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    while (!cfg_gnt && n < 20) begin @(posedge clk); #1; n++; end
    ok = 0; rd = 'x; er = 'x;
    if (cfg_gnt) begin
      @(posedge clk); #1;
      ok = cfg_rvalid; rd = cfg_rdata; er = cfg_err;
    end
    cfg_req = 0; cfg_we = 0;
  endtask

  task automatic commit(output logic ok);
    logic [63:0] rd; logic er, cok; int n = 0;
    cfg_xfer(1, 8'hF0, 64'h1, rd, er, cok);
    while (!lookup_ready && n < 10) begin @(posedge clk); #1; n++; end
    ok = cok && (er === 1'b0) && lookup_ready;
    model_commit();
  endtask

  task automatic do_lookup(input logic [63:0] a, output logic v1, output logic v2,
                           output logic h, output logic [2:0] ix, output logic [2:0] at);
    lookup_valid = 1; lookup_addr = a;
    @(posedge clk); #1;
    v1 = resp_valid; lookup_valid = 0;
    @(posedge clk); #1;
    v2 = resp_valid; h = resp_hit; ix = resp_idx; at = resp_attr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [63:0] rd, erd; logic er, eer, ok;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_hit, resp_idx, resp_attr, cfg_rvalid, cfg_err} !== '0 || cfg_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rv=%0b hit=%0b idx=%0d attr=%03b crv=%0b err=%0b rd=%h want all zero",
               resp_valid, resp_hit, resp_idx, resp_attr, cfg_rvalid, cfg_err, cfg_rdata);
    end
    checks++;
    if ({lookup_ready, cfg_gnt} !== 2'b11) begin
      errors++; $display("FAIL reset_ready_gnt got %02b want 11", {lookup_ready, cfg_gnt});
    end
    rst_n = 1; model_reset();
    @(posedge clk); #1;
    foreach (sh_base[k]) begin end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a;
      a = 8'(k * 8);
      cfg_xfer(0, a, 0, rd, er, ok); model_cfg(0, a, 0, erd, eer);
      checks++;
      if (!ok || rd !== erd || er !== eer) begin
        errors++; $display("FAIL reset_region0_reg off=%h got ok=%0b rd=%h err=%0b want rd=%h err=%0b",
                           a, ok, rd, er, erd, eer);
      end
    end
  endtask

  task automatic test_lookup_reset();
    logic [63:0] addrs [4];
    logic v1, v2, h, eh; logic [2:0] ix, at, eix, eat;
    addrs = '{64'h8000_0000, 64'h7FFF_FFFF, 64'hC000_0000, 64'hBFFF_FFFF};
    for (int k = 0; k < 4; k++) begin
      do_lookup(addrs[k], v1, v2, h, ix, at);
      model_lookup(addrs[k], eh, eix, eat);
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || {h, ix, at} !== {eh, eix, eat}) begin
        errors++; $display("FAIL lookup_reset addr=%h got v1=%0b v2=%0b hit=%0b idx=%0d attr=%03b want 0 1 %0b %0d %03b",
                           addrs[k], v1, v2, h, ix, at, eh, eix, eat);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0]  oa [6];
    logic        owe [6];
    logic [63:0] rd, erd; logic er, eer, ok;
    oa  = '{8'hE0, 8'h18, 8'h04, 8'h70, 8'h28, 8'hF8};
    owe = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      cfg_xfer(owe[k], oa[k], 64'h7F, rd, er, ok); model_cfg(owe[k], oa[k], 64'h7F, erd, eer);
      checks++;
      if (!ok || rd !== erd || er !== eer) begin
        errors++; $display("FAIL err_decode off=%h we=%0b got ok=%0b rd=%h err=%0b want rd=%h err=%0b",
                           oa[k], owe[k], ok, rd, er, erd, eer);
      end
    end
    // ATTR bits 6:4 are not stored
    cfg_xfer(0, 8'h70, 0, rd, er, ok); model_cfg(0, 8'h70, 0, erd, eer);
    checks++;
    if (!ok || rd !== erd || er !== eer) begin
      errors++; $display("FAIL attr_mask got rd=%h err=%0b want rd=%h err=%0b", rd, er, erd, eer);
    end
  endtask

  task automatic test_overlap();
    logic [7:0]  wa [6];
    logic [63:0] wd [6];
    logic [63:0] la [4];
    logic [63:0] rd, erd; logic er, eer, ok, v1, v2, h, eh; logic [2:0] ix, at, eix, eat;
    wa = '{8'h20, 8'h28, 8'h30, 8'h40, 8'h48, 8'h50};
    wd = '{64'h1000, 64'h1000, 64'h0F, 64'h0, 64'h10000, 64'h09};
    for (int k = 0; k < 6; k++) begin
      cfg_xfer(1, wa[k], wd[k], rd, er, ok); model_cfg(1, wa[k], wd[k], erd, eer);
    end
    commit(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overlap_commit got ok=0 want 1"); end
    la = '{64'h1800, 64'h3000, 64'h1000, 64'h2000};
    for (int k = 0; k < 4; k++) begin
      do_lookup(la[k], v1, v2, h, ix, at); model_lookup(la[k], eh, eix, eat);
      checks++;
      if (v2 !== 1'b1 || {h, ix, at} !== {eh, eix, eat}) begin
        errors++; $display("FAIL overlap addr=%h got v=%0b hit=%0b idx=%0d attr=%03b want 1 %0b %0d %03b",
                           la[k], v2, h, ix, at, eh, eix, eat);
      end
    end
  endtask

  task automatic test_commit_atomic();
    logic [63:0] rd, erd; logic er, eer, ok, oh, nh;
    logic [2:0] oi, oat, ni, nat;
    cfg_xfer(1, 8'h60, 64'h2000_0000, rd, er, ok); model_cfg(1, 8'h60, 64'h2000_0000, erd, eer);
    cfg_xfer(1, 8'h68, 64'h100, rd, er, ok);       model_cfg(1, 8'h68, 64'h100, erd, eer);
    cfg_xfer(1, 8'h70, 64'h0B, rd, er, ok);        model_cfg(1, 8'h70, 64'h0B, erd, eer);
    // T: commit and lookup together
    cfg_req = 1; cfg_we = 1; cfg_addr = 8'hF0; cfg_wdata = 1;
    lookup_valid = 1; lookup_addr = 64'h2000_0010;
    model_lookup(lookup_addr, oh, oi, oat);
    checks++;
    if ({cfg_gnt, lookup_ready} !== 2'b11) begin
      errors++; $display("FAIL atomic_T_gnt_ready got %02b want 11", {cfg_gnt, lookup_ready});
    end
    @(posedge clk); #1;
    // T+1: status read request is held off
    cfg_we = 0; cfg_addr = 8'hF8;
    checks++;
    if ({lookup_ready, cfg_gnt, resp_valid} !== 3'b000 || cfg_rvalid !== 1'b1 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL atomic_T1 got rdy=%0b gnt=%0b rv=%0b crv=%0b err=%0b want 0 0 0 1 0",
                         lookup_ready, cfg_gnt, resp_valid, cfg_rvalid, cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if ({lookup_ready, cfg_gnt} !== 2'b00 || resp_valid !== 1'b1 || {resp_hit, resp_idx, resp_attr} !== {oh, oi, oat}) begin
      errors++; $display("FAIL atomic_T2_old got rdy=%0b gnt=%0b rv=%0b hit=%0b idx=%0d attr=%03b want 0 0 1 %0b %0d %03b",
                         lookup_ready, cfg_gnt, resp_valid, resp_hit, resp_idx, resp_attr, oh, oi, oat);
    end
    @(posedge clk); #1;
    model_commit();
    model_lookup(lookup_addr, nh, ni, nat);
    checks++;
    if ({lookup_ready, cfg_gnt, resp_valid} !== 3'b110) begin
      errors++; $display("FAIL atomic_T3 got rdy=%0b gnt=%0b rv=%0b want 1 1 0", lookup_ready, cfg_gnt, resp_valid);
    end
    @(posedge clk); #1;
    cfg_req = 0; lookup_valid = 0;
    checks++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== 64'h0 || cfg_err !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL atomic_status got crv=%0b rd=%h err=%0b rv=%0b want 1 0 0 0",
                         cfg_rvalid, cfg_rdata, cfg_err, resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || {resp_hit, resp_idx, resp_attr} !== {nh, ni, nat}) begin
      errors++; $display("FAIL atomic_new got rv=%0b hit=%0b idx=%0d attr=%03b want 1 %0b %0d %03b",
                         resp_valid, resp_hit, resp_idx, resp_attr, nh, ni, nat);
    end
  endtask

  task automatic test_lock();
    logic [63:0] rd, erd; logic er, eer, ok, v1, v2, h, eh; logic [2:0] ix, at, eix, eat;
    logic [63:0] la [3];
    cfg_xfer(1, 8'h10, 64'h8F, rd, er, ok); model_cfg(1, 8'h10, 64'h8F, erd, eer);
    commit(ok);
    cfg_xfer(1, 8'h00, 64'h1234_0000, rd, er, ok); model_cfg(1, 8'h00, 64'h1234_0000, erd, eer);
    checks++;
    if (!ok || er !== eer || rd !== erd) begin
      errors++; $display("FAIL lock_write_err got ok=%0b err=%0b rd=%h want err=%0b rd=%h", ok, er, rd, eer, erd);
    end
    cfg_xfer(1, 8'h20, 64'h5000, rd, er, ok); model_cfg(1, 8'h20, 64'h5000, erd, eer);
    cfg_xfer(1, 8'h28, 64'h100, rd, er, ok);  model_cfg(1, 8'h28, 64'h100, erd, eer);
    cfg_xfer(1, 8'h30, 64'h0D, rd, er, ok);   model_cfg(1, 8'h30, 64'h0D, erd, eer);
    commit(ok);
    la = '{64'h5080, 64'h8000_0000, 64'h1800};
    for (int k = 0; k < 3; k++) begin
      do_lookup(la[k], v1, v2, h, ix, at); model_lookup(la[k], eh, eix, eat);
      checks++;
      if (v2 !== 1'b1 || {h, ix, at} !== {eh, eix, eat}) begin
        errors++; $display("FAIL lock_lookup addr=%h got hit=%0b idx=%0d attr=%03b want %0b %0d %03b",
                           la[k], h, ix, at, eh, eix, eat);
      end
    end
  endtask

  function automatic logic [63:0] pick_addr();
    int k = $urandom_range(1, NR - 1);
    case ($urandom_range(0, 5))
      0: return ac_base[k];
      1: return ac_base[k] + ac_len[k] - 64'd1;
      2: return ac_base[k] + ac_len[k];
      3: return 64'h7FFF_FFFF + 64'($urandom_range(0, 2)) * 64'h4000_0000;
      default: return 64'($urandom_range(0, 'h14000));
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] rd, erd, d; logic [7:0] a; logic er, eer, ok;
    logic v, acc, ch, ph, pv; logic [2:0] ci, ca, pi, pa;
    for (int round = 0; round < 5; round++) begin
      for (int k = 1; k < NR; k++) begin
        for (int f = 0; f < 3; f++) begin
          a = 8'(k * 32 + f * 8);
          d = (f == 0) ? 64'($urandom_range(0, 'hF000)) :
              (f == 1) ? 64'($urandom_range(0, 'h4000)) : 64'($urandom_range(0, 127));
          cfg_xfer(1, a, d, rd, er, ok); model_cfg(1, a, d, erd, eer);
          checks++;
          if (!ok || er !== eer) begin
            errors++; $display("FAIL rand_cfg off=%h got ok=%0b err=%0b want err=%0b", a, ok, er, eer);
          end
        end
      end
      commit(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_commit round=%0d got ok=0 want 1", round); end
      pv = 0; ph = 0; pi = 0; pa = 0;
      for (int c = 0; c < 45; c++) begin
        v = (c < 40) && ($urandom_range(0, 3) != 0);
        lookup_valid = v; lookup_addr = pick_addr();
        acc = v && lookup_ready;
        ch = 0; ci = 0; ca = 0;
        if (acc) model_lookup(lookup_addr, ch, ci, ca);
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== pv || (pv && {resp_hit, resp_idx, resp_attr} !== {ph, pi, pa})) begin
          errors++; $display("FAIL rand_lookup round=%0d cyc=%0d got v=%0b hit=%0b idx=%0d attr=%03b want v=%0b %0b %0d %03b",
                             round, c, resp_valid, resp_hit, resp_idx, resp_attr, pv, ph, pi, pa);
        end
        pv = acc; ph = ch; pi = ci; pa = ca;
      end
      lookup_valid = 0;
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] rd, erd; logic er, eer, ok, seen, v1, v2, h, eh; logic [2:0] ix, at, eix, eat;
    cfg_req = 1; cfg_we = 1; cfg_addr = 8'hF0; cfg_wdata = 1;
    lookup_valid = 1; lookup_addr = 64'h8000_0000;
    @(posedge clk); #1;
    cfg_req = 0; cfg_we = 0; lookup_valid = 0;
    checks++;
    if (lookup_ready !== 1'b0) begin
      errors++; $display("FAIL async_in_drain got ready=%0b want 0", lookup_ready);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({resp_valid, resp_hit, resp_idx, resp_attr, cfg_rvalid, cfg_err} !== '0 || cfg_rdata !== '0 ||
        {lookup_ready, cfg_gnt} !== 2'b11) begin
      errors++; $display("FAIL async_outputs got rv=%0b crv=%0b rdy=%0b gnt=%0b want 0 0 1 1",
                         resp_valid, cfg_rvalid, lookup_ready, cfg_gnt);
    end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid !== 1'b0) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL async_no_resp got pulse=1 want 0"); end
    rst_n = 1; model_reset();
    cfg_xfer(0, 8'h10, 0, rd, er, ok); model_cfg(0, 8'h10, 0, erd, eer);
    checks++;
    if (!ok || rd !== erd || er !== eer) begin
      errors++; $display("FAIL async_region0_attr got rd=%h err=%0b want rd=%h err=%0b", rd, er, erd, eer);
    end
    do_lookup(64'h1800, v1, v2, h, ix, at); model_lookup(64'h1800, eh, eix, eat);
    checks++;
    if (v2 !== 1'b1 || {h, ix, at} !== {eh, eix, eat}) begin
      errors++; $display("FAIL async_lookup got hit=%0b idx=%0d attr=%03b want %0b %0d %03b",
                         h, ix, at, eh, eix, eat);
    end
  endtask

  initial begin
    test_reset();
    test_lookup_reset();
    test_errors();
    test_overlap();
    test_commit_atomic();
    test_lock();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
